// File: rtl/bcd_scan_display.sv
// bcd_scan_display: latches a 4-digit BCD value and scans it onto a
// multiplexed seven-segment display with leading-zero blanking.
module bcd_scan_display #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] bcd_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        bcd_err
);

    localparam int unsigned PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0]  SEG_DASH   = 7'h40;
    localparam logic [6:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF     = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [2:0] {
        ST_DARK = 3'd0,
        ST_D0   = 3'd1,
        ST_D1   = 3'd2,
        ST_D2   = 3'd3,
        ST_D3   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] latch_q, latch_d;
    logic        err_q, err_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic [1:0]  digit_sel_q, digit_sel_d;

    logic        tick_c;
    logic [3:0]  nib_zero_c;
    logic [3:0]  upper_zero_c;
    logic [1:0]  slot_idx;
    logic [3:0]  slot_nib;
    logic [6:0]  slot_raw;
    logic        slot_blank;

    // Active-high segment pattern for one nibble; non-decimal shows a dash.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] r;
        case (nib)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = SEG_DASH;
        endcase
        return r;
    endfunction

    // Digit position driven in a given scan state.
    function automatic logic [1:0] state_idx(input state_e s);
        logic [1:0] r;
        case (s)
            ST_D1:   r = 2'd1;
            ST_D2:   r = 2'd2;
            ST_D3:   r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Prescaler wrap and latch update.
    always_comb begin
        tick_c      = (prescaler_q == PW'(SCAN_DIV - 1));
        prescaler_d = tick_c ? '0 : prescaler_q + PW'(1);
        latch_d     = latch_q;
        err_d       = err_q;
        if (load) begin
            latch_d = bcd_in;
            err_d   = (bcd_in[3:0] > 4'd9) || (bcd_in[7:4] > 4'd9) ||
                      (bcd_in[11:8] > 4'd9) || (bcd_in[15:12] > 4'd9);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler_q <= '0;
            latch_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            latch_q     <= latch_d;
            err_q       <= err_d;
        end
    end

    // Scan state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_DARK;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan next-state: advance one digit per tick, dark only until the first tick.
    always_comb begin
        state_d = state_q;
        if (tick_c) begin
            case (state_q)
                ST_DARK: state_d = ST_D0;
                ST_D0:   state_d = ST_D1;
                ST_D1:   state_d = ST_D2;
                ST_D2:   state_d = ST_D3;
                ST_D3:   state_d = ST_D0;
                default: state_d = ST_DARK;
            endcase
        end
    end

    // Leading-zero detection: upper_zero_c[k] means nibbles k..3 are all zero.
    always_comb begin
        nib_zero_c[0]   = (latch_q[3:0]   == 4'd0);
        nib_zero_c[1]   = (latch_q[7:4]   == 4'd0);
        nib_zero_c[2]   = (latch_q[11:8]  == 4'd0);
        nib_zero_c[3]   = (latch_q[15:12] == 4'd0);
        upper_zero_c[3] = nib_zero_c[3];
        upper_zero_c[2] = nib_zero_c[3] & nib_zero_c[2];
        upper_zero_c[1] = nib_zero_c[3] & nib_zero_c[2] & nib_zero_c[1];
        upper_zero_c[0] = 1'b0;
    end

    // Output next-values: recomputed on tick for the incoming state, from the pre-load latch.
    always_comb begin
        seg_d       = seg_q;
        an_d        = an_q;
        digit_sel_d = digit_sel_q;
        slot_idx    = state_idx(state_d);
        slot_nib    = 4'd0;
        slot_raw    = 7'h00;
        slot_blank  = 1'b0;
        if (tick_c && (state_d != ST_DARK)) begin
            case (slot_idx)
                2'd1:    slot_nib = latch_q[7:4];
                2'd2:    slot_nib = latch_q[11:8];
                2'd3:    slot_nib = latch_q[15:12];
                default: slot_nib = latch_q[3:0];
            endcase
            slot_blank  = BLANK_LEADING && upper_zero_c[slot_idx];
            slot_raw    = slot_blank ? 7'h00 : seg_encode(slot_nib);
            seg_d       = SEG_ACTIVE_LOW ? ~slot_raw : slot_raw;
            an_d        = AN_ACTIVE_LOW ? ~(4'b0001 << slot_idx) : (4'b0001 << slot_idx);
            digit_sel_d = slot_idx;
        end
    end

    // Display output registers; dark during and after reset until the first tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
            digit_sel_q <= 2'd0;
        end else begin
            seg_q       <= seg_d;
            an_q        <= an_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign digit_sel = digit_sel_q;
    assign bcd_err   = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display with SCAN_DIV=4 and active-low pins.
// Expected slots carry the clk edge (counted from reset release) at which they must appear.
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        bcd_err;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [1:0]  dsel;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int unsigned cyc = 0;
    logic [3:0]  prev_an = 4'hF;

    bcd_scan_display #(
        .SCAN_DIV(4),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .bcd_in(bcd_in),
        .seg(seg),
        .an(an),
        .digit_sel(digit_sel),
        .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push(input int unsigned c, input logic [3:0] a, input logic [6:0] s,
                        input logic [1:0] d, input logic e);
        exp_t x;
        x.cyc = c; x.an = a; x.seg = s; x.dsel = d; x.err = e;
        exp_q.push_back(x);
    endtask

    // Push four consecutive slots starting at edge c.
    task automatic push4(input int unsigned c, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input logic e);
        push(c,      4'b1110, s0, 2'd0, e);
        push(c + 4,  4'b1101, s1, 2'd1, e);
        push(c + 8,  4'b1011, s2, 2'd2, e);
        push(c + 12, 4'b0111, s3, 2'd3, e);
    endtask

    // Wait (bounded) for the negedge at which cyc == target.
    task automatic wait_cyc(input int unsigned target);
        int n;
        n = 0;
        @(negedge clk);
        while (cyc != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) begin
            n_cmp++; n_mis++;
            $display("FAIL wait_cyc: reached cyc=%0d, required cyc=%0d", cyc, target);
        end
    endtask

    // Present load so it is sampled at edge e.
    task automatic do_load(input int unsigned e, input logic [15:0] v);
        wait_cyc(e - 1);
        load = 1'b1;
        bcd_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_dark(input string name);
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || digit_sel !== 2'd0 || bcd_err !== 1'b0) begin
            n_mis++;
            $display("FAIL %s: an=%b seg=%h dsel=%0d err=%b, required an=1111 seg=7f dsel=0 err=0",
                     name, an, seg, digit_sel, bcd_err);
        end
    endtask

    // Monitor: each new digit slot pops one expectation and compares it.
    always @(negedge clk) begin
        if (!reset) begin
            prev_an = an;
        end else if (an !== prev_an) begin
            prev_an = an;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL slot_unexpected: cyc=%0d an=%b seg=%h, required no slot change",
                         cyc, an, seg);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (cyc != x.cyc || an !== x.an || seg !== x.seg ||
                    digit_sel !== x.dsel || bcd_err !== x.err) begin
                    n_mis++;
                    $display("FAIL slot: got cyc=%0d an=%b seg=%h dsel=%0d err=%b, required cyc=%0d an=%b seg=%h dsel=%0d err=%b",
                             cyc, an, seg, digit_sel, bcd_err, x.cyc, x.an, x.seg, x.dsel, x.err);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_dark("reset_state");

        // No load: digit0 shows "0", others blanked.
        push4(4, 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0);
        reset = 1'b1;
        wait_cyc(2);
        check_dark("dark_before_first_tick");

        // 1234h
        do_load(17, 16'h1234);
        push4(20, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0);
        // 0070h: leading zeros blanked, d0 zero kept
        do_load(33, 16'h0070);
        push4(36, 7'h40, 7'h78, 7'h7F, 7'h7F, 1'b0);
        // 9A09h: error flag, dash on d2, inner zero not blanked
        do_load(49, 16'h9A09);
        push4(52, 7'h10, 7'h40, 7'h3F, 7'h10, 1'b1);
        // 0001h clears error
        do_load(65, 16'h0001);
        push4(68, 7'h79, 7'h7F, 7'h7F, 7'h7F, 1'b0);
        // 1111h, then 2222h loaded on the tick edge 84
        do_load(81, 16'h1111);
        push(84, 4'b1110, 7'h79, 2'd0, 1'b0);
        push(88, 4'b1101, 7'h24, 2'd1, 1'b0);
        push(92, 4'b1011, 7'h24, 2'd2, 1'b0);
        do_load(84, 16'h2222);

        // Reset mid-slot while d2 is shown.
        wait_cyc(93);
        #2 reset = 1'b0;
        #1 check_dark("async_reset_mid_slot");
        push(4, 4'b1110, 7'h40, 2'd0, 1'b0);
        push(8, 4'b1101, 7'h7F, 2'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(10);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL slots_pending: %0d slots never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Consumes the 16-bit, 4-digit BCD count produced by the frequency-measurement counter.
- Drives a 4-digit multiplexed common-anode seven-segment display.
- Latches a new value on a load strobe, then time-multiplexes the digits at a programmable scan rate.
- Provides leading-zero blanking and flags non-BCD nibbles.

Parameters:
- SCAN_DIV, 1000: clk cycles per digit slot; legal range ≥2.
- SEG_ACTIVE_LOW, 1: 1 inverts seg outputs at the pin (common-anode).
- AN_ACTIVE_LOW, 1: 1 means an[k]=0 enables digit k.
- BLANK_LEADING, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load  in  1  single-cycle strobe; latch bcd_in
- bcd_in  in  16  {d3,d2,d1,d0} BCD nibbles, d0 = least significant
- seg  out  7  {g,f,e,d,c,b,a} segment drive, polarity per SEG_ACTIVE_LOW
- an  out  4  digit enables, one-hot when active, polarity per AN_ACTIVE_LOW
- digit_sel  out  2  index of the digit currently driven
- bcd_err  out  1  sticky flag: latched value contains a nibble >9

Behaviour:
- Reset is asynchronous, active-low. While reset=0 and afterwards until the first scan tick:
  - latch=0, prescaler=0, digit_sel=0, bcd_err=0.
  - an = all inactive; seg = all segments off (at pin polarity).
- Latch:
  - On posedge clk with load=1, latch<=bcd_in.
  - bcd_err<=1 if any nibble of bcd_in >9, else 0.
  - load=0: latch and bcd_err hold.
- Prescaler:
  - Counts 0..SCAN_DIV-1 every clk and wraps to 0.
  - tick is asserted in the cycle where prescaler==SCAN_DIV-1.
- Digit FSM, states S0→S1→S2→S3→S0, advancing on tick:
  - The first tick after reset enters S0 and enables an/seg.
  - Subsequent ticks advance the state; S3 wraps to S0.
  - digit_sel = current state index.
- Outputs:
  - seg, an and digit_sel are registered and update on the same edge as the state change.
  - They are constant for exactly SCAN_DIV cycles per slot.
- Segment encoding, active-high before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, bit0=a).
  - Nibble A–F displays dash (40h).
- Blanking (BLANK_LEADING=1):
  - Digit k (k=3,2,1) is blanked (seg off, an still enabled) if every latched nibble at index ≥k is 0.
  - Digit 0 is never blanked, so value 0000 shows "0".
  - Invalid nibbles are never treated as zero.
- Simultaneous load and tick:
  - The output register samples the pre-load latch value.
  - The new value appears from the next slot onward.
- Reset mid-scan: immediate return to the reset state; outputs go dark asynchronously.
- Load during blanking: blanking is re-evaluated per slot from the current latch, with no extra state.

Test Plan (SCAN_DIV=4, both polarities active-low):
- Reset released, no load:
  - an=1111, seg=7F until cycle 3 tick.
  - Then an=1110, seg=~3F=40 (digit0 "0").
  - an=1101, 1011, 0111 show blank (seg=7F) in successive 4-cycle slots.
- load with bcd_in=1234h:
  - Slots show d0 seg=~66=19, d1 ~4F=30, d2 ~5B=24, d3 ~06=79.
  - an cycles 1110,1101,1011,0111; bcd_err=0.
- load with bcd_in=0070h:
  - d0 "0" (40), d1 "7" (78).
  - d2 and d3 blanked (7F).
- load with bcd_in=9A09h:
  - bcd_err=1; d2 shows dash (~40=3F).
  - d3 "9" not blanked.
  - Next load of 0001h clears bcd_err.
- load asserted in the same cycle as a tick, changing 1111h→2222h:
  - The slot starting at that edge shows "1".
  - The following slot shows "2".
- reset pulsed low mid-slot while showing d2:
  - an=1111 and seg=7F asynchronously.
  - After release, digit0 of value 0000 appears at the 4th clk edge.
